// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the RAM slave: FSM state codes,
// bus width constants and width helper functions.
package wb_pkg;

    localparam int WB_BYTE_W     = 8;
    localparam int WB_WAIT_CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    function automatic int selWidth(input int dataW);
        return dataW / WB_BYTE_W;
    endfunction

    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_ram_bytelane.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read
// port that clears to zero whenever no read is requested.
module wb_ram_bytelane
    import wb_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 1024,
    localparam int SEL_W  = selWidth(DATA_W),
    localparam int IDX_W  = idxWidth(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [SEL_W-1:0]  i_wrEn,
    input  logic [DATA_W-1:0] i_wrDat,
    input  logic              i_rdEn,
    output logic [DATA_W-1:0] o_rdDat
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdDat;

    // Array contents are deliberately left out of reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < SEL_W; lane++) begin
            if (i_wrEn[lane]) begin
                r_mem[i_idx][lane*WB_BYTE_W +: WB_BYTE_W] <= i_wrDat[lane*WB_BYTE_W +: WB_BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdDat <= '0;
        end else if (i_rdEn) begin
            r_rdDat <= r_mem[i_idx];
        end else begin
            r_rdDat <= '0;
        end
    end

    assign o_rdDat = r_rdDat;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic-cycle single-port RAM slave with wait states and byte lanes.
// Define WB_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    localparam int               SEL_W       = selWidth(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic [SEL_W-1:0]  wb_sel_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o
);

    localparam int LSB_W = $clog2(SEL_W);
    localparam int IDX_W = idxWidth(DEPTH);
    localparam logic [WB_WAIT_CNT_W-1:0] LAST_WAIT = WB_WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                   r_state;
    logic [WB_WAIT_CNT_W-1:0] r_waitCnt;
    logic [ADDR_W-1:0]        r_adr;
    logic                     r_we;
    logic [DATA_W-1:0]        r_dat;
    logic [SEL_W-1:0]         r_sel;
    logic                     r_err;

    logic                     w_req;
    logic [ADDR_W-1:0]        w_curAdr;
    logic                     w_curWe;
    logic [ADDR_W-1:0]        w_off;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_toResp;
    logic                     w_respLive;
    logic                     w_inRange;
    logic                     w_rdEn;
    logic [SEL_W-1:0]         w_wrEn;
    logic                     w_unusedOff;

    assign w_req = wb_cyc_i & wb_stb_i;

    // With zero wait states the read happens on the accepting edge, before the latch holds the address.
    assign w_curAdr = (r_state == IDLE) ? wb_adr_i : r_adr;
    assign w_curWe  = (r_state == IDLE) ? wb_we_i  : r_we;
    assign w_off    = w_curAdr - BASE_ADDR;
    assign w_idx    = w_off[LSB_W +: IDX_W];
    assign w_unusedOff = ^w_off;

`ifdef WB_ERR_EN
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] SPAN = AW1'(DEPTH * SEL_W);
    assign w_inRange = ({1'b0, w_off} < SPAN);
`else
    assign w_inRange = 1'b1;
`endif

    assign w_toResp = (r_state == IDLE && w_req && WAIT_STATES == 0)
                   || (r_state == WAIT && wb_cyc_i && r_waitCnt == LAST_WAIT);

    // Dropping cyc during the response cycle suppresses both the handshake and the write.
    assign w_respLive = (r_state == RESP) && wb_cyc_i;
    assign w_rdEn     = w_toResp && !w_curWe && w_inRange;
    assign w_wrEn     = (w_respLive && r_we && !r_err) ? r_sel : '0;

    assign wb_ack_o = w_respLive && !r_err;
`ifdef WB_ERR_EN
    assign wb_err_o = w_respLive && r_err;
`else
    assign wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
            r_adr     <= '0;
            r_we      <= 1'b0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_adr     <= wb_adr_i;
                        r_we      <= wb_we_i;
                        r_dat     <= wb_dat_i;
                        r_sel     <= wb_sel_i;
                        r_waitCnt <= '0;
                        r_state   <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        r_state <= IDLE;
                    end else if (r_waitCnt == LAST_WAIT) begin
                        r_state <= RESP;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_toResp) begin
                r_err <= !w_inRange;
            end
        end
    end

    wb_ram_bytelane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_idx   (w_idx),
        .i_wrEn  (w_wrEn),
        .i_wrDat (r_dat),
        .i_rdEn  (w_rdEn),
        .o_rdDat (wb_dat_o)
    );

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: directed vector table, multi-cycle corner
// sequences and randomized traffic against a word/byte-level memory model.
module tb_wb_ram_slave;

    localparam int          WS    = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          CLK_P = 10;
    localparam int          NVEC  = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] expDat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] datI;
    logic [3:0]  sel;
    logic [31:0] datO;
    logic        ack;
    logic        err;

    int          nChecks = 0;
    int          nFail   = 0;
    time         lastAckTime = 0;
    logic [31:0] mMem   [DEPTH];
    logic [3:0]  mKnown [DEPTH];
    vec_t        vecs   [NVEC];

    wb_ram_slave #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (datI),
        .wb_sel_i (sel),
        .wb_dat_o (datO),
        .wb_ack_o (ack),
        .wb_err_o (err)
    );

    initial clk = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    initial begin
        #(200000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic bit modelInRange(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < longint'(DEPTH) * 4);
    endfunction

    function automatic bit modelIsErr(input logic [31:0] a);
`ifdef WB_ERR_EN
        return !modelInRange(a);
`else
        return 1'b0 & modelInRange(a);
`endif
    endfunction

    function automatic int modelIdx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] knownMask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        if (!modelIsErr(a)) begin
            i = modelIdx(a);
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    mMem[i][8*b +: 8] = d[8*b +: 8];
                    mKnown[i][b] = 1'b1;
                end
            end
        end
    endtask

    // One complete classic-cycle transfer: drive, watch every cycle up to the response, release.
    task automatic applyStimulus(input logic iWe, input logic [31:0] iAdr, input logic [31:0] iDat,
                                 input logic [3:0] iSel, input bit holdCyc, input bit expErr,
                                 input bit chkDat, input logic [31:0] expDat, input logic [31:0] datMask,
                                 input string name);
        logic [31:0] ackPat;
        logic [31:0] errPat;
        logic [31:0] respDat;
        logic [31:0] idleDat;
        ackPat = '0; errPat = '0; respDat = '0; idleDat = '0;
        cyc = 1'b1; stb = 1'b1; we = iWe; adr = iAdr; datI = iDat; sel = iSel;
        @(posedge clk);
        for (int n = 1; n <= WS + 1; n++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                ackPat[n] = 1'b1;
                lastAckTime = $time;
            end
            if (err === 1'b1) errPat[n] = 1'b1;
            if (n == WS + 1) respDat = datO;
            else idleDat = idleDat | datO;
        end
        checkOutput({name, ":ackCycle"}, ackPat, expErr ? 32'h0 : (32'h1 << (WS + 1)));
        checkOutput({name, ":errCycle"}, errPat, expErr ? (32'h1 << (WS + 1)) : 32'h0);
        checkOutput({name, ":datBeforeResp"}, idleDat, 32'h0);
        if (chkDat) checkOutput({name, ":data"}, respDat & datMask, expDat & datMask);
        @(posedge clk);
        #1;
        stb = 1'b0;
        if (!holdCyc) cyc = 1'b0;
        checkOutput({name, ":ackErrAfter"}, {30'h0, ack, err}, 32'h0);
        checkOutput({name, ":datAfter"}, datO, 32'h0);
    endtask

    task automatic modelTransfer(input logic iWe, input logic [31:0] iAdr, input logic [31:0] iDat,
                                 input logic [3:0] iSel, input bit holdCyc, input string name);
        bit          isErr;
        logic [31:0] expD;
        logic [31:0] mask;
        isErr = modelIsErr(iAdr);
        if (iWe) begin
            applyStimulus(1'b1, iAdr, iDat, iSel, holdCyc, isErr, 1'b0, 32'h0, 32'h0, name);
            modelWrite(iAdr, iDat, iSel);
        end else begin
            if (isErr) begin
                expD = 32'h0;
                mask = 32'hFFFF_FFFF;
            end else begin
                expD = mMem[modelIdx(iAdr)];
                mask = knownMask(mKnown[modelIdx(iAdr)]);
            end
            applyStimulus(1'b0, iAdr, 32'h0, 4'h0, holdCyc, isErr, mask != 0, expD, mask, name);
        end
    endtask

    task automatic watchQuiet(input int cycles, output bit seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack !== 1'b0 || err !== 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        bit          seen;
        time         prevAck;
        logic [31:0] rAdr;
        logic [31:0] readBack;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h0102_0304};
        vecs[8]  = '{1'b1, 32'h0000_0026, 32'hAA00_0000, 4'h8, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0027, 32'h0,         4'h0, 32'hAA02_0304};
        vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h1234_5678};
        vecs[12] = '{1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0034, 32'h600D_CAFE, 4'hF, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_0038, 32'h1357_9BDF, 4'hF, 32'h0};
        vecs[15] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0};

        for (int i = 0; i < DEPTH; i++) begin
            mMem[i]   = 32'h0;
            mKnown[i] = 4'h0;
        end

        // Reset held with a live request: nothing may respond.
        reset = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
        adr = 32'h10; datI = 32'hFFFF_FFFF; sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset%0d:ack", i), {31'h0, ack}, 32'h0);
            checkOutput($sformatf("reset%0d:err", i), {31'h0, err}, 32'h0);
            checkOutput($sformatf("reset%0d:dat", i), datO, 32'h0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].we) begin
                applyStimulus(1'b1, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0, 1'b0, 1'b0,
                              32'h0, 32'h0, $sformatf("vec%0d", i));
                modelWrite(vecs[i].adr, vecs[i].dat, vecs[i].sel);
            end else begin
                applyStimulus(1'b0, vecs[i].adr, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1,
                              vecs[i].expDat, 32'hFFFF_FFFF, $sformatf("vec%0d", i));
            end
        end

        // Abort while waiting: cyc drops one cycle after the strobe is accepted.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; datI = 32'h5555_AAAA; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        watchQuiet(5, seen);
        checkOutput("abortWait:noResp", {31'h0, seen}, 32'h0);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D, 32'hFFFF_FFFF, "abortWaitRead");

        // Abort in the response cycle: cyc released right after the edge that enters it.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h34; datI = 32'h0000_1111; sel = 4'hF;
        @(posedge clk);
        repeat (WS) @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        watchQuiet(5, seen);
        checkOutput("abortResp:noResp", {31'h0, seen}, 32'h0);
        applyStimulus(1'b0, 32'h34, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h600D_CAFE, 32'hFFFF_FFFF, "abortRespRead");

        // Strobe without cycle is ignored.
        @(negedge clk);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h38; datI = 32'h2222_3333; sel = 4'hF;
        watchQuiet(5, seen);
        stb = 1'b0;
        checkOutput("stbNoCyc:noResp", {31'h0, seen}, 32'h0);

        // Reset during the wait phase discards the pending write.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h38; datI = 32'hFFFF_0000; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack !== 1'b0 || err !== 1'b0 || datO !== 32'h0) seen = 1'b1;
        end
        checkOutput("midReset:quietInReset", {31'h0, seen}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        watchQuiet(5, seen);
        checkOutput("midReset:noResp", {31'h0, seen}, 32'h0);
        applyStimulus(1'b0, 32'h38, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF, 32'hFFFF_FFFF, "midResetRead");

        // One past the top of the array: error response or alias onto word 0.
`ifdef WB_ERR_EN
        applyStimulus(1'b1, 32'h1000, 32'h7777_8888, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, "outOfRangeWrite");
        readBack = 32'hA5A5_A5A5;
`else
        applyStimulus(1'b1, 32'h1000, 32'h7777_8888, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "outOfRangeWrite");
        readBack = 32'h7777_8888;
`endif
        modelWrite(32'h1000, 32'h7777_8888, 4'hF);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, readBack, 32'hFFFF_FFFF, "word0Read");

        // Back-to-back reads with cyc held: fixed ack spacing and in-order data.
        for (int k = 0; k < 8; k++) begin
            modelTransfer(1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF, 1'b0, $sformatf("b2bFill%0d", k));
        end
        prevAck = 0;
        for (int k = 0; k < 8; k++) begin
            modelTransfer(1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, k != 7, $sformatf("b2bRead%0d", k));
            if (k > 0) begin
                checkOutput($sformatf("b2b%0d:period", k), 32'(lastAckTime - prevAck), 32'((WS + 2) * CLK_P));
            end
            prevAck = lastAckTime;
        end

        // Randomized traffic, some of it beyond the array.
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 7) == 0) rAdr = 32'h1000 + ($urandom & 32'h0000_0FFF);
            else rAdr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            modelTransfer(1'($urandom_range(0, 1)), rAdr, $urandom, 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
